div_iter_param: RTL and testbench

- Parametrised multicycle restoring divider for the EXE stage; successor to the fixed 32-bit, 1-bit-per-cycle divider.
- Supports:
  - configurable operand width;
  - configurable quotient bits retired per cycle;
  - signed and unsigned modes;
  - cancel;
  - an explicit divide-by-zero flag;
  - separate quotient and remainder outputs.
- Operands are latched at start, so upstream may change op1/op2 while the divide runs.
- The HI/LO writeback logic consumes rem/quot when done is high.

---
 rtl/div_iter_param.sv | 263 ++++++++++++++++++++++++++
 tb/tb_div_iter_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_iter_param
// Description : Parametrised multicycle restoring divider for the EXE stage.
//               It retires STEPS quotient bits per RUN cycle and supports
//               signed and unsigned modes, cancel, and an explicit
//               divide-by-zero flag. It returns the quotient and remainder
//               separately. Operands are captured on the start edge.
//
//               Parameters:
//                 WIDTH  operand, quotient and remainder width (>= 4)
//                 STEPS  quotient bits per RUN cycle (1, 2 or 4);
//                        WIDTH must be a multiple of STEPS
//                 CNT_W  iteration counter width; 2**CNT_W > WIDTH/STEPS
//
//               Ports:
//                 clk          rising-edge clock
//                 reset        synchronous active-high reset
//                 en           request level, held until result consumed
//                 cancel       abort from a later stage (exception/flush)
//                 sign_flag    1 = signed (DIV), 0 = unsigned (DIVU)
//                 op1 / op2    dividend / divisor
//                 busy         high whenever not IDLE
//                 done         result valid, held until en falls
//                 div_by_zero  qualifies done: divisor was zero
//                 quot / rem   quotient / remainder
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module div_iter_param #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cancel,
    input  logic             sign_flag,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_zero = 3'd1;
    localparam logic [2:0] c_st_run  = 3'd2;
    localparam logic [2:0] c_st_fix  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    // Counter value seen on the final RUN edge.
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH / STEPS - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_divisor;   // |op2|
    logic [WIDTH-1:0] r_prem;      // partial remainder
    // Dividend bits shift out of the top while quotient bits enter at the
    // bottom, so after the last iteration this holds the raw quotient.
    // In the ZERO path it carries the raw op1 instead.
    logic [WIDTH-1:0] r_qsh;
    logic             r_signed;
    logic             r_s1;
    logic             r_s2;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_done;
    logic             r_dbz;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic             w_start;
    logic             w_op2_zero;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_prem_nxt;
    logic [WIDTH-1:0] w_qsh_nxt;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_start    = en && !cancel;
    assign w_op2_zero = (op2 == '0);

    // Magnitudes: negate only for a signed request with the MSB set.
    // The signed minimum maps to the unsigned value 2**(WIDTH-1), which is
    // exactly its magnitude, so MIN / -1 needs no special case.
    assign w_neg1 = sign_flag && op1[WIDTH-1];
    assign w_neg2 = sign_flag && op2[WIDTH-1];
    assign w_mag1 = w_neg1 ? (~op1 + 1'b1) : op1;
    assign w_mag2 = w_neg2 ? (~op2 + 1'b1) : op2;

    // STEPS chained restoring iterations, each on a WIDTH+1-bit trial
    // subtract. The partial remainder is always below the divisor, so the
    // shifted value fits in WIDTH+1 bits and a negative trial result
    // leaves a shifted value that fits back into WIDTH bits.
    always_comb begin
        w_prem_nxt = r_prem;
        w_qsh_nxt  = r_qsh;
        w_shift    = '0;
        w_trial    = '0;
        for (int i = 0; i < STEPS; i++) begin
            w_shift = {w_prem_nxt, w_qsh_nxt[WIDTH-1]};
            w_trial = w_shift - {1'b0, r_divisor};
            if (w_trial[WIDTH]) begin
                w_prem_nxt = w_shift[WIDTH-1:0];
                w_qsh_nxt  = {w_qsh_nxt[WIDTH-2:0], 1'b0};
            end else begin
                w_prem_nxt = w_trial[WIDTH-1:0];
                w_qsh_nxt  = {w_qsh_nxt[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Sign correction uses the MSBs captured at start, never the live
    // operands. The remainder takes the sign of the dividend.
    assign w_quot_fix = (r_signed && (r_s1 ^ r_s2)) ? (~r_qsh + 1'b1) : r_qsh;
    assign w_rem_fix  = (r_signed && r_s1)          ? (~r_prem + 1'b1) : r_prem;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_state_nxt = w_op2_zero ? c_st_zero : c_st_run;
                end
            end
            c_st_zero: begin
                w_state_nxt = c_st_done;
            end
            c_st_run: begin
                if (cancel) begin
                    w_state_nxt = c_st_idle;
                end else if (r_count == c_last_cnt) begin
                    w_state_nxt = c_st_fix;
                end
            end
            c_st_fix: begin
                w_state_nxt = cancel ? c_st_idle : c_st_done;
            end
            c_st_done: begin
                // A falling en or a cancel releases the result; a new
                // request always passes through IDLE first.
                if (!en || cancel) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_divisor <= '0;
            r_prem    <= '0;
            r_qsh     <= '0;
            r_signed  <= 1'b0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_quot <= '0;
                    r_rem  <= '0;
                    r_done <= 1'b0;
                    r_dbz  <= 1'b0;
                    if (w_start) begin
                        r_signed  <= sign_flag;
                        r_s1      <= op1[WIDTH-1];
                        r_s2      <= op2[WIDTH-1];
                        r_count   <= '0;
                        r_prem    <= '0;
                        r_divisor <= w_mag2;
                        // The zero path reports the raw dividend as remainder.
                        r_qsh     <= w_op2_zero ? op1 : w_mag1;
                    end
                end
                c_st_zero: begin
                    r_quot <= '1;
                    r_rem  <= r_qsh;
                    r_dbz  <= 1'b1;
                    r_done <= 1'b1;
                end
                c_st_run: begin
                    if (!cancel) begin
                        r_prem  <= w_prem_nxt;
                        r_qsh   <= w_qsh_nxt;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                c_st_fix: begin
                    if (!cancel) begin
                        r_quot <= w_quot_fix;
                        r_rem  <= w_rem_fix;
                        r_dbz  <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                c_st_done: begin
                    if (!en || cancel) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_dbz  <= 1'b0;
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy        = (r_state != c_st_idle);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign quot        = r_quot;
    assign rem         = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_param
// Description : Self-checking bench for div_iter_param. Four configurations
//               (32/1, 32/2, 32/4, 16/1) share one stimulus stream. Expected
//               results come from a magnitude-based reference model and go
//               through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        cancel;
    logic        sign_flag;
    logic [31:0] op1;
    logic [31:0] op2;

    always #5 clk = ~clk;

    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  dbz_v;
    logic [31:0] q0, q1, q2, r0, r1, r2;
    logic [15:0] q3, r3;
    logic [31:0] quot_v [4];
    logic [31:0] rem_v  [4];

    assign quot_v[0] = q0;
    assign quot_v[1] = q1;
    assign quot_v[2] = q2;
    assign quot_v[3] = {16'h0, q3};
    assign rem_v[0]  = r0;
    assign rem_v[1]  = r1;
    assign rem_v[2]  = r2;
    assign rem_v[3]  = {16'h0, r3};

    div_iter_param #(.WIDTH(32), .STEPS(1), .CNT_W(6)) u_w32_s1 (
        .clk(clk), .reset(reset), .en(en), .cancel(cancel), .sign_flag(sign_flag),
        .op1(op1), .op2(op2), .busy(busy_v[0]), .done(done_v[0]),
        .div_by_zero(dbz_v[0]), .quot(q0), .rem(r0));

    div_iter_param #(.WIDTH(32), .STEPS(2), .CNT_W(5)) u_w32_s2 (
        .clk(clk), .reset(reset), .en(en), .cancel(cancel), .sign_flag(sign_flag),
        .op1(op1), .op2(op2), .busy(busy_v[1]), .done(done_v[1]),
        .div_by_zero(dbz_v[1]), .quot(q1), .rem(r1));

    div_iter_param #(.WIDTH(32), .STEPS(4), .CNT_W(4)) u_w32_s4 (
        .clk(clk), .reset(reset), .en(en), .cancel(cancel), .sign_flag(sign_flag),
        .op1(op1), .op2(op2), .busy(busy_v[2]), .done(done_v[2]),
        .div_by_zero(dbz_v[2]), .quot(q2), .rem(r2));

    div_iter_param #(.WIDTH(16), .STEPS(1), .CNT_W(5)) u_w16_s1 (
        .clk(clk), .reset(reset), .en(en), .cancel(cancel), .sign_flag(sign_flag),
        .op1(op1[15:0]), .op2(op2[15:0]), .busy(busy_v[3]), .done(done_v[3]),
        .div_by_zero(dbz_v[3]), .quot(q3), .rem(r3));

    // Per-instance width and normal-path latency (WIDTH/STEPS + 2).
    int wid     [4] = '{32, 32, 32, 16};
    int lat_run [4] = '{34, 18, 10, 18};

    typedef struct packed {
        logic [3:0]       dbz;
        logic [3:0][31:0] q;
        logic [3:0][31:0] r;
        logic [3:0][7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Truncating division on magnitudes: quotient sign = sign1 ^ sign2,
    // remainder sign = dividend sign. Returns {dbz, quot, rem}.
    function automatic logic [64:0] ref_div(input int w, input logic sgn,
                                            input logic [31:0] a_in,
                                            input logic [31:0] b_in);
        logic [31:0] mask, a, b, ma, mb, q, r;
        logic        na, nb;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a  = a_in & mask;
        b  = b_in & mask;
        if (b == 0) return {1'b1, mask, a};
        na = sgn && a[w-1];
        nb = sgn && b[w-1];
        ma = na ? ((~a + 1) & mask) : a;
        mb = nb ? ((~b + 1) & mask) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = (~q + 1) & mask;
        if (na)      r = (~r + 1) & mask;
        return {1'b0, q, r};
    endfunction

    // One full transaction: start, catch each instance's done at its own
    // latency, check the held result, then release and check the clear.
    task automatic run_op(input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble);
        exp_t        e;
        exp_t        cur;
        logic [64:0] m;
        logic [3:0]  seen;
        @(negedge clk);
        en = 1'b1; sign_flag = sgn; op1 = a; op2 = b;
        for (int i = 0; i < 4; i++) begin
            m         = ref_div(wid[i], sgn, a, b);
            e.dbz[i]  = m[64];
            e.q[i]    = m[63:32];
            e.r[i]    = m[31:0];
            e.lat[i]  = m[64] ? 8'd2 : 8'(lat_run[i]);
        end
        sb.push_back(e);
        seen = '0;
        for (int k = 1; k <= 40 && seen != 4'hF; k++) begin
            @(posedge clk); #1;
            if (scramble && k == 1) begin
                op1 = $urandom; op2 = $urandom; sign_flag = ~sgn;
            end
            for (int i = 0; i < 4; i++) begin
                if (!seen[i] && done_v[i]) begin
                    seen[i] = 1'b1;
                    cur = sb[0];
                    n_vec++;
                    if (k != int'(cur.lat[i]) || quot_v[i] !== cur.q[i] ||
                        rem_v[i] !== cur.r[i] || dbz_v[i] !== cur.dbz[i]) begin
                        n_err++;
                        $display("FAIL result[%0d] %h/%h s=%b: lat=%0d quot=%h rem=%h dbz=%b, expected lat=%0d quot=%h rem=%h dbz=%b",
                                 i, a, b, sgn, k, quot_v[i], rem_v[i], dbz_v[i],
                                 cur.lat[i], cur.q[i], cur.r[i], cur.dbz[i]);
                    end
                end
            end
        end
        cur = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (!seen[i] || done_v[i] !== 1'b1 || quot_v[i] !== cur.q[i] ||
                rem_v[i] !== cur.r[i] || dbz_v[i] !== cur.dbz[i]) begin
                n_err++;
                $display("FAIL held[%0d] %h/%h: seen=%b done=%b quot=%h rem=%h, expected done=1 quot=%h rem=%h",
                         i, a, b, seen[i], done_v[i], quot_v[i], rem_v[i], cur.q[i], cur.r[i]);
            end
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || dbz_v[i] !== 1'b0 ||
                quot_v[i] !== 32'h0 || rem_v[i] !== 32'h0) begin
                n_err++;
                $display("FAIL release[%0d]: busy=%b done=%b dbz=%b quot=%h rem=%h, expected all zero",
                         i, busy_v[i], done_v[i], dbz_v[i], quot_v[i], rem_v[i]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; cancel = 1'b0; sign_flag = 1'b0;
        op1 = 32'h0; op2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || dbz_v[i] !== 1'b0 ||
                quot_v[i] !== 32'h0 || rem_v[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset[%0d]: busy=%b done=%b dbz=%b quot=%h rem=%h, expected all zero",
                         i, busy_v[i], done_v[i], dbz_v[i], quot_v[i], rem_v[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        run_op(1'b0, 32'd100,        32'd7,        1'b0);
        run_op(1'b1, 32'hFFFF_FFF9,  32'd2,        1'b0);
        run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 1'b0);
        run_op(1'b0, 32'hFFFF_FFF9,  32'd2,        1'b0);
        run_op(1'b0, 32'h1234_5678,  32'h0,        1'b0);
        run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(1'b1, 32'h0,          32'd5,        1'b0);
        run_op(1'b0, 32'hFFFF_FFFF,  32'd1,        1'b0);
    endtask

    task automatic test_cancel;
        logic [3:0] rose;
        rose = '0;
        @(negedge clk);
        en = 1'b1; sign_flag = 1'b0; op1 = 32'd1000; op2 = 32'd3;
        // Edge 1 is the start edge, so edge 11 is the 10th RUN edge.
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            rose = rose | done_v;
            if (k == 10) cancel = 1'b1;
        end
        cancel = 1'b0; en = 1'b0;
        // The STEPS=4 instance finishes at edge 10, so only the slower
        // instances are expected never to raise done.
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || (i != 2 && rose[i])) begin
                n_err++;
                $display("FAIL cancel_run[%0d]: busy=%b done=%b rose=%b, expected 0 0 0",
                         i, busy_v[i], done_v[i], rose[i]);
            end
        end
        // en together with cancel in IDLE must not start anything.
        @(negedge clk);
        en = 1'b1; cancel = 1'b1; op1 = 32'd50; op2 = 32'd5;
        @(posedge clk); #1;
        n_vec++;
        if (busy_v !== 4'h0) begin
            n_err++;
            $display("FAIL cancel_idle: busy=%b, expected 0000", busy_v);
        end
        cancel = 1'b0; en = 1'b0;
        // Fresh request right after, with operands scrambled mid-run.
        run_op(1'b0, 32'd50, 32'd5, 1'b1);
        run_op(1'b1, 32'hFFFF_FF38, 32'd9, 1'b1);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        en = 1'b1; sign_flag = 1'b1; op1 = 32'h7654_3210; op2 = 32'd3;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk); #1;
            if (k == 20) reset = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 ||
                quot_v[i] !== 32'h0 || rem_v[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: busy=%b done=%b quot=%h rem=%h, expected all zero",
                         i, busy_v[i], done_v[i], quot_v[i], rem_v[i]);
            end
        end
        // reset wins over a simultaneous request.
        @(posedge clk); #1;
        n_vec++;
        if (busy_v !== 4'h0) begin
            n_err++;
            $display("FAIL reset_with_en: busy=%b, expected 0000", busy_v);
        end
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        case ($urandom_range(0, 5))
            0:       return allow_zero ? 32'h0 : 32'd1;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 300));
            4:       return {16'($urandom), 16'h8000 | 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            a = pick_operand(1'b1);
            b = ($urandom_range(0, 15) == 0) ? 32'h0 : pick_operand(1'b0);
            run_op(1'($urandom_range(0, 1)), a, b, bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
